// File: rtl/interrupt_controller_pkg.sv
// Shared CP0 definitions: controller FSM encoding, Status bit positions,
// CP0 register numbers and the fixed-priority helper.
package interrupt_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAKE    = 2'd1,
    ST_SERVICE = 2'd2
  } ic_state_t;

  localparam int NUM_LINES    = 4;
  localparam int STATUS_IE    = 0;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 11;

  localparam int CP0_REG_STATUS = 12;
  localparam int CP0_REG_CAUSE  = 13;
  localparam int CP0_REG_EPC    = 14;

  // Lowest set index wins; returns 0 for an empty request vector.
  function automatic logic [1:0] prio_index(input logic [NUM_LINES-1:0] req);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (req[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU-facing bundle of the interrupt controller: request lines, CP0 inputs,
// and the exception-entry strobes back to the CPU.
interface interrupt_controller_if;
  logic [3:0]  irq_i;
  logic [31:0] status_i;
  logic        inst_done;
  logic [31:0] pc_i;
  logic        eret;
  logic        EPCWrite;
  logic        CauseWrite;
  logic [1:0]  IntCause;
  logic [31:0] epc_o;
  logic        int_take;
  logic [31:0] vector_o;
  logic        in_service;

  modport master (
    output irq_i, status_i, inst_done, pc_i, eret,
    input  EPCWrite, CauseWrite, IntCause, epc_o, int_take, vector_o, in_service
  );

  modport slave (
    input  irq_i, status_i, inst_done, pc_i, eret,
    output EPCWrite, CauseWrite, IntCause, epc_o, int_take, vector_o, in_service
  );
endinterface

// File: rtl/interrupt_controller_irq_edge_latch.sv
// Rising-edge detector plus sticky pending register for the interrupt lines.
// A new edge on a line outranks a clear of that same line in the same cycle.
module irq_edge_latch
  import interrupt_controller_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LINES-1:0] irq_i,
  input  logic                 clr_valid,
  input  logic [1:0]           clr_idx,
  output logic [NUM_LINES-1:0] pending_o
);

  logic [NUM_LINES-1:0] irq_prev_reg;
  logic [NUM_LINES-1:0] pending_reg;
  logic [NUM_LINES-1:0] edge_det;
  logic [NUM_LINES-1:0] clr_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
      assign edge_det[gi] = irq_i[gi] & ~irq_prev_reg[gi];
      assign clr_mask[gi] = clr_valid && (clr_idx == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev_reg <= '0;
      pending_reg  <= '0;
    end else begin
      irq_prev_reg <= irq_i;
      pending_reg  <= (pending_reg & ~clr_mask) | edge_det;
    end
  end

  assign pending_o = pending_reg;

endmodule

// File: rtl/interrupt_controller.sv
// Four-line vectored interrupt controller: masks pending requests with CP0
// Status, picks the lowest line, and sequences IDLE -> TAKE -> SERVICE.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter logic [31:0] HANDLER_VECTOR = 32'h0000_0004
) (
  input  logic                   clk,
  input  logic                   rst,
  interrupt_controller_if.slave  bus
);

  ic_state_t            state_reg;
  logic [1:0]           cause_reg;
  logic [31:0]          epc_reg;
  logic [NUM_LINES-1:0] pending;
  logic [NUM_LINES-1:0] eligible;
  logic                 unused_status_bits;

  irq_edge_latch u_edge_latch (
    .clk       (clk),
    .rst       (rst),
    .irq_i     (bus.irq_i),
    .clr_valid (state_reg == ST_TAKE),
    .clr_idx   (cause_reg),
    .pending_o (pending)
  );

  assign eligible = pending & bus.status_i[STATUS_IM_HI:STATUS_IM_LO]
                  & {NUM_LINES{bus.status_i[STATUS_IE]}};
  assign unused_status_bits = ^{bus.status_i[31:STATUS_IM_HI+1],
                                bus.status_i[STATUS_IM_LO-1:STATUS_IE+1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cause_reg <= 2'd0;
      epc_reg   <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if ((eligible != '0) && bus.inst_done) begin
            state_reg <= ST_TAKE;
            cause_reg <= prio_index(eligible);
            epc_reg   <= bus.pc_i;
          end
        end
        ST_TAKE:    state_reg <= ST_SERVICE;
        ST_SERVICE: if (bus.eret) state_reg <= ST_IDLE;
        default:    state_reg <= ST_IDLE;
      endcase
    end
  end

  // Strobes are pure state decodes so no input can reach an output combinationally.
  assign bus.EPCWrite   = (state_reg == ST_TAKE);
  assign bus.CauseWrite = (state_reg == ST_TAKE);
  assign bus.int_take   = (state_reg == ST_TAKE);
  assign bus.in_service = (state_reg == ST_SERVICE);
  assign bus.IntCause   = cause_reg;
  assign bus.epc_o      = epc_reg;
  assign bus.vector_o   = HANDLER_VECTOR;

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized + directed bench for interrupt_controller with a queue-based
// scoreboard fed by a cycle-level reference model of the controller rules.
module tb_interrupt_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  interrupt_controller_if bus();

  interrupt_controller #(.HANDLER_VECTOR(32'h0000_0004)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int dut_takes = 0;

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] epc;
  } take_t;
  take_t exp_q[$];

  // Reference model: phase 0 = waiting, 1 = entry cycle, 2 = handler running.
  logic [3:0]  m_prev  = '0;
  logic [3:0]  m_pend  = '0;
  int          m_phase = 0;
  logic [1:0]  m_cause = '0;
  logic [31:0] m_epc   = '0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  always @(posedge clk) begin : model
    logic [3:0] elig;
    logic [3:0] rises;
    int w;
    take_t t;
    if (rst) begin
      m_prev = '0; m_pend = '0; m_phase = 0; m_cause = '0; m_epc = '0;
      exp_q.delete();
    end else begin
      elig  = m_pend & bus.status_i[11:8] & {4{bus.status_i[0]}};
      rises = bus.irq_i & ~m_prev;
      if (m_phase == 0) begin
        if (elig != 4'd0 && bus.inst_done) begin
          w = 0;
          for (int i = 3; i >= 0; i--) if (elig[i]) w = i;
          m_cause = w[1:0];
          m_epc   = bus.pc_i;
          t.cause = m_cause;
          t.epc   = m_epc;
          exp_q.push_back(t);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_pend[m_cause] = 1'b0;
        m_phase = 2;
      end else if (bus.eret) begin
        m_phase = 0;
      end
      m_pend = m_pend | rises;
      m_prev = bus.irq_i;
    end
  end

  always @(negedge clk) begin : monitor
    take_t t;
    if (rst) begin
      chk("reset_outputs", {bus.int_take, bus.EPCWrite, bus.CauseWrite, bus.in_service}, 4'b0000);
    end else begin
      chk("strobes", {bus.int_take, bus.EPCWrite, bus.CauseWrite}, {3{m_phase == 1}});
      chk("in_service", bus.in_service, m_phase == 2);
      if (bus.int_take === 1'b1) begin
        dut_takes++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_take actual=IntCause %0d required=no take", bus.IntCause);
        end else begin
          t = exp_q.pop_front();
          chk("take_cause", bus.IntCause, t.cause);
          chk("take_epc", bus.epc_o, t.epc);
        end
      end
      chk("held_cause_epc", {bus.IntCause, bus.epc_o}, {m_cause, m_epc});
    end
  end

  task automatic step(input logic [3:0] irq, input logic [31:0] st, input logic id,
                      input logic [31:0] pc, input logic er);
    bus.irq_i = irq; bus.status_i = st; bus.inst_done = id; bus.pc_i = pc; bus.eret = er;
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(string nm);
    chk({nm, "_strobes"}, {bus.int_take, bus.EPCWrite, bus.CauseWrite, bus.in_service}, 4'b0000);
    chk({nm, "_cause_epc"}, {bus.IntCause, bus.epc_o}, 34'd0);
    chk({nm, "_vector"}, bus.vector_o, 32'h0000_0004);
  endtask

  localparam logic [31:0] ST_ON = 32'h0000_0F01;

  initial begin
    int base;
    logic [3:0]  irq;
    logic [31:0] st;
    bus.irq_i = '0; bus.status_i = '0; bus.inst_done = 1'b0; bus.pc_i = '0; bus.eret = 1'b0;
    @(posedge clk); #2;
    check_reset_values("por");
    @(posedge clk); #2;
    rst = 1'b0;
    step(4'b0000, ST_ON, 1'b1, 32'h0, 1'b0);

    // Single request on line 2
    step(4'b0100, ST_ON, 1'b1, 32'h0000_0040, 1'b0);
    step(4'b0100, ST_ON, 1'b1, 32'h0000_0040, 1'b0);
    step(4'b0100, ST_ON, 1'b1, 32'h0000_0044, 1'b0);
    step(4'b0100, ST_ON, 1'b1, 32'h0000_0048, 1'b0);
    chk("single_cause", bus.IntCause, 2'd2);
    chk("single_epc", bus.epc_o, 32'h0000_0040);
    chk("single_in_service", bus.in_service, 1'b1);
    chk("single_take_count", dut_takes, 1);
    step(4'b0100, ST_ON, 1'b1, 32'h0, 1'b1);
    step(4'b0000, ST_ON, 1'b1, 32'h0, 1'b0);
    step(4'b0000, ST_ON, 1'b1, 32'h0, 1'b0);
    chk("held_high_no_retake", dut_takes, 1);

    // Simultaneous requests on lines 1 and 3
    for (int i = 0; i < 4; i++) step(4'b1010, ST_ON, 1'b1, 32'h100 + 32'(i), 1'b0);
    chk("prio_first_cause", bus.IntCause, 2'd1);
    step(4'b1010, ST_ON, 1'b1, 32'h200, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b1010, ST_ON, 1'b1, 32'h200, 1'b0);
    chk("prio_second_cause", bus.IntCause, 2'd3);
    chk("prio_take_count", dut_takes, 3);
    step(4'b0000, ST_ON, 1'b1, 32'h0, 1'b1);
    step(4'b0000, ST_ON, 1'b1, 32'h0, 1'b0);

    // Masked line 0 stays pending until IM[0] opens
    base = dut_takes;
    for (int i = 0; i < 5; i++) step(4'b0001, 32'h0000_0E01, 1'b1, 32'h300, 1'b0);
    chk("masked_no_take", dut_takes, base);
    for (int i = 0; i < 4; i++) step(4'b0001, ST_ON, 1'b1, 32'h304, 1'b0);
    chk("unmasked_cause", bus.IntCause, 2'd0);
    chk("unmasked_take_count", dut_takes, base + 1);

    // New edge during SERVICE must wait for eret
    step(4'b0000, ST_ON, 1'b1, 32'h400, 1'b0);
    for (int i = 0; i < 5; i++) step(4'b0001, ST_ON, 1'b1, 32'h404, 1'b0);
    chk("no_nesting", dut_takes, base + 1);
    step(4'b0001, ST_ON, 1'b1, 32'h408, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0001, ST_ON, 1'b1, 32'h40C, 1'b0);
    chk("after_eret_take_count", dut_takes, base + 2);
    chk("after_eret_epc", bus.epc_o, 32'h40C);
    step(4'b0000, ST_ON, 1'b1, 32'h0, 1'b1);

    // Instruction-boundary gating
    base = dut_takes;
    for (int i = 0; i < 6; i++) step(4'b0010, ST_ON, 1'b0, 32'h500, 1'b0);
    chk("gated_no_take", dut_takes, base);
    step(4'b0010, ST_ON, 1'b1, 32'h504, 1'b0);
    chk("gate_open_take", bus.int_take, 1'b1);
    step(4'b0010, ST_ON, 1'b1, 32'h508, 1'b0);
    step(4'b0010, ST_ON, 1'b1, 32'h508, 1'b0);
    chk("gate_in_service", bus.in_service, 1'b1);

    // Asynchronous reset while in SERVICE
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    bus.irq_i = 4'b0000;
    step(4'b0000, ST_ON, 1'b1, 32'h600, 1'b0);
    rst = 1'b0;
    base = dut_takes;
    for (int i = 0; i < 5; i++) step(4'b0000, ST_ON, 1'b1, 32'h600, 1'b0);
    chk("post_reset_quiet", dut_takes, base);

    // Line already high at reset release counts as one request
    rst = 1'b1;
    step(4'b1000, ST_ON, 1'b1, 32'h700, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(4'b1000, ST_ON, 1'b1, 32'h704, 1'b0);
    chk("high_at_release_cause", {bus.in_service, bus.IntCause}, 3'b111);
    step(4'b1000, ST_ON, 1'b1, 32'h0, 1'b1);

    // Random traffic
    irq = 4'b1000;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) irq[b] = ~irq[b];
      case ($urandom_range(5))
        0: st = 32'h0000_0E01;
        1: st = 32'h0000_0F00;
        2: st = 32'h0000_0501;
        3: st = $urandom;
        default: st = ST_ON;
      endcase
      if ($urandom_range(299) == 0) rst = 1'b1;
      else rst = 1'b0;
      step(irq, st, $urandom_range(3) != 0, $urandom, $urandom_range(5) == 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 4; i++) step(4'b0000, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("random_takes_seen", dut_takes > 20, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 The block SHALL have parameter HANDLER_VECTOR, default 32'h0000_0004: the handler entry address driven on vector_o.
REQ-002 The block SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- irq_i  in  4  peripheral request lines, level; a rising edge is a request
- status_i  in  32  CP0 Status; bit0 = global IE, bits[11:8] = per-line mask IM[3:0]
- inst_done  in  1  CPU is at an instruction boundary this cycle
- pc_i  in  32  address of the next instruction (return address)
- eret  in  1  one-cycle pulse on ERET execution
- EPCWrite  out  1  write epc_o into CP0 EPC
- CauseWrite  out  1  write IntCause into CP0 Cause
- IntCause  out  2  index of the interrupt taken
- epc_o  out  32  latched return address
- int_take  out  1  CPU loads PC from vector_o
- vector_o  out  32  constant HANDLER_VECTOR
- in_service  out  1  handler executing; nesting blocked

Function
REQ-004 The block SHALL register irq_i into irq_prev every cycle; edge[n] = irq_i[n] & ~irq_prev[n].
REQ-005 pending[n] SHALL set on the clock edge where edge[n]=1 and clear only when line n is taken; if set and clear coincide for the same line, set SHALL win.
REQ-006 Eligible SHALL be pending & status_i[11:8] & {4{status_i[0]}}. Masked requests SHALL stay pending.
REQ-007 Priority SHALL be fixed, with the lowest index highest (line 0 first).
REQ-008 The FSM SHALL have states IDLE, TAKE and SERVICE.
REQ-009 In IDLE, if eligible != 0 and inst_done = 1, the FSM SHALL go to TAKE. On that edge it SHALL latch the winning index into cause_q and pc_i into epc_q.
REQ-010 In TAKE, for exactly one cycle, EPCWrite = CauseWrite = int_take = 1 and pending[cause_q] SHALL clear. The FSM SHALL then go unconditionally to SERVICE.
REQ-011 In SERVICE, in_service = 1 and no new interrupt SHALL be taken. On eret = 1 the FSM SHALL go to IDLE; pending bits SHALL continue to accumulate.
REQ-012 eret in IDLE or TAKE SHALL be ignored.
REQ-013 All outputs SHALL be registered or decoded from state only (Moore), with no combinational path from inputs.
REQ-014 IntCause SHALL equal cause_q[1:0] and epc_o SHALL equal epc_q; both SHALL hold their value until the next TAKE.
REQ-015 Latency: a rising edge sampled at edge k, with IE/IM enabled and inst_done = 1 in cycle k+1, SHALL put the FSM in TAKE after edge k+1 and in SERVICE after edge k+2.
REQ-016 A request arriving while in TAKE or SERVICE SHALL be taken at the first inst_done after the return to IDLE.
REQ-017 A line held high SHALL produce one request only; a new request requires a low-to-high transition.

Reset
REQ-018 While rst = 1, and immediately on assertion, the following SHALL hold: state = IDLE, pending = 0, irq_prev = 0, cause_q = 0, epc_q = 0.
REQ-019 While rst = 1, and immediately on assertion, all outputs SHALL be 0 except vector_o = HANDLER_VECTOR.
REQ-020 Reset asserted mid-TAKE or mid-SERVICE SHALL abort the operation with no residual write strobe.
REQ-021 Because irq_prev resets to 0, a line already high at reset release SHALL register as one request.

Structure
REQ-022 FSM state encodings, the Status bit positions (IE = 0, IM = 11:8) and the CP0 register numbers (Status 12, Cause 13, EPC 14) SHALL live in the shared CP0 definitions package.
REQ-023 Edge detection plus the pending register SHALL be one sub-module, irq_edge_latch (ports: clk, rst, irq_i, clr_valid, clr_idx, pending_o).
REQ-024 The priority encoder and FSM SHALL stay in interrupt_controller.

Verification
REQ-025 Single request: status_i = 32'h0000_0F01, irq_i[2] rises, inst_done = 1, pc_i = 32'h0000_0040 -> one cycle with EPCWrite = CauseWrite = int_take = 1, IntCause = 2, epc_o = 32'h40; in_service = 1 until eret.
REQ-026 Priority: irq_i[1] and irq_i[3] rise in the same cycle -> first TAKE has IntCause = 1; after eret, second TAKE has IntCause = 3.
REQ-027 Masking: status_i = 32'h0000_0E01, irq_i[0] rises -> no take. Then status_i = 32'h0000_0F01 -> take with IntCause = 0.
REQ-028 No nesting: irq_i[0] rises during SERVICE -> no strobe until eret; then take at the first inst_done.
REQ-029 Boundary gating: pending eligible with inst_done = 0 for 5 cycles -> no take. inst_done = 1 -> TAKE on the next edge.
REQ-030 Reset in SERVICE: rst pulse -> in_service = 0, pending = 0, and no strobes are asserted afterwards without a new edge.
